fetch_unit_l4: RTL
==================

// Module: fetch_unit_l4
// PURPOSE
//  Decoupled fetch stage. Issues 4-byte instruction reads to memory and buffers returned instructions in an in-order fetch queue.
//  Each instruction leaves for decode (D) with a PC and a sequence number.
//  Tracks issued-but-uncommitted instructions against a configurable in-flight limit, and redirects on squash.
//  Stale memory responses are discarded by epoch tagging; prior generation used a single in-flight stream with no queue.
// PARAMETERS
//  p_opaq_bits      8           mem opaque width; bit [0] carries epoch, must be >=1
//  p_seq_num_bits   5           seq num width; 2**p_seq_num_bits seq nums in ring
//  p_max_in_flight  16          max instructions sent to D and not yet committed/squashed (<=2**p_seq_num_bits)
//  p_buf_depth      4           fetch queue entries (power of 2, >=2); also caps outstanding mem requests
//  p_reset_pc       32'h200     PC fetched first after reset
// PORTS
//  clk              in   1      clock
//  rst              in   1      reset, asynchronous, active-high
//  mem_req_val      out  1      mem read request valid
//  mem_req_rdy      in   1      mem ready for request
//  mem_req_addr     out  32     fetch PC (word aligned)
//  mem_req_opaque   out  p_opaq_bits   {0.., epoch}
//  mem_resp_val     in   1      mem response valid
//  mem_resp_rdy     out  1      always 1 (queue space pre-reserved at request)
//  mem_resp_opaque  in   p_opaq_bits   echoed opaque
//  mem_resp_data    in   32     instruction word
//  D_val / D_rdy    out/in 1    decode handshake
//  D_inst           out  32     instruction
//  D_pc             out  32     instruction PC
//  D_seq_num        out  p_seq_num_bits  allocated seq num
//  commit_val       in   1      commit notification
//  commit_seq_num   in   p_seq_num_bits  committing instr (always the oldest allocated)
//  squash_val       in   1      squash notification
//  squash_seq_num   in   p_seq_num_bits  instr causing squash; it and older stay allocated
//  squash_target    in   32     redirect PC
// BEHAVIOUR
//  State: fetch_pc, epoch (1b), num_reserved (issued reqs + queued entries, 0..p_buf_depth),
//  queue (pc, inst, head/tail ptrs), seq_head (oldest allocated), seq_tail (next to allocate),
//  num_in_flight (0..p_max_in_flight).
//  Reset (async): fetch_pc=p_reset_pc, epoch=0, queue empty, num_reserved=0, seq_head=seq_tail=0, num_in_flight=0.
//  Reset outputs: mem_req_val=0, D_val=0, mem_resp_rdy=1.
//  Request: mem_req_val = num_reserved<p_buf_depth && !squash_val.
//   On req fire: pc entry pushed to pending-PC FIFO, fetch_pc+=4 (mod 2**32), num_reserved++.
//  Response: if opaque[0]==epoch, data written to queue with its PC and the entry becomes visible.
//   Otherwise it is dropped and num_reserved-- that cycle. Responses return in request order.
//  D: D_val = queue non-empty && num_in_flight<p_max_in_flight && !squash_val. Queue head drives D_inst/D_pc; D_seq_num=seq_tail.
//   On D fire: pop, num_reserved--, seq_tail++ (wraps mod 2**p_seq_num_bits), num_in_flight++.
//   Min latency req fire -> D_val: 1 cycle after mem_resp_val (registered queue).
//  Commit: seq_head++, num_in_flight--. commit_seq_num!=seq_head is an assertion failure.
//  Squash (registered next edge):
//   - fetch_pc=squash_target, epoch flips, queue flushed.
//   - num_reserved = count of requests still outstanding; they will be dropped as stale.
//   - seq_tail=squash_seq_num+1; num_in_flight=seq_tail_new-seq_head (mod ring).
//   - No mem req and no D fire in the squash cycle.
//  Same-cycle commit+squash: commit applied first, then squash recomputes num_in_flight.
//  Same-cycle resp+D fire+req fire: all legal; counters use net delta.
//  Full: num_reserved==p_buf_depth blocks requests; num_in_flight==p_max_in_flight blocks D only, fetch continues until queue fills.
//  Two squashes before old responses drain: epoch is 1 bit; a second squash is legal only after num_reserved outstanding reqs from epoch-2 have returned.
//   Unit holds mem_req_val=0 until outstanding stale reqs drain.
// TESTING
//  1 Reset then free-run, mem delay 0: D sees pc 0x200,0x204,0x208 with seq 0,1,2 and insts from mem image.
//  2 p_max_in_flight=4, no commits: exactly 4 D transfers (seq 0..3), then D_val=0. commit(0) -> seq 4 pc 0x210 issued.
//  3 Seq wrap, p_seq_num_bits=2: commit each after D; seq runs 0,1,2,3,0,1 with pcs continuing +4.
//  4 Squash(seq 1, target 0x400) with 3 responses outstanding, mem delay 3: stale data never reaches D; next D is pc 0x400 seq 2.
//  5 Commit(0)+squash(2,0x800) same cycle after seq 0..4 issued: next D is pc 0x800 seq 3, in-flight count 2.
//  6 D_rdy random-delay 9 and mem delays 9: ordered pc/seq stream with no drop or duplicate; reset asserted mid-stream restarts at 0x200 seq 0.

Source files
------------

// File: rtl/fetch_unit_l4.sv
`default_nettype none
// ============================================================================
// fetch_unit_l4 : decoupled fetch stage with epoch-tagged squash recovery
// Rev 1.0
// ============================================================================
module fetch_unit_l4 #(
    parameter int          p_opaq_bits     = 8,
    parameter int          p_seq_num_bits  = 5,
    parameter int          p_max_in_flight = 16,
    parameter int          p_buf_depth     = 4,
    parameter logic [31:0] p_reset_pc      = 32'h200
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic [31:0]               mem_req_addr,
    output logic [p_opaq_bits-1:0]    mem_req_opaque,
    input  logic                      mem_resp_val,
    output logic                      mem_resp_rdy,
    input  logic [p_opaq_bits-1:0]    mem_resp_opaque,
    input  logic [31:0]               mem_resp_data,
    output logic                      D_val,
    input  logic                      D_rdy,
    output logic [31:0]               D_inst,
    output logic [31:0]               D_pc,
    output logic [p_seq_num_bits-1:0] D_seq_num,
    input  logic                      commit_val,
    input  logic [p_seq_num_bits-1:0] commit_seq_num,
    input  logic                      squash_val,
    input  logic [p_seq_num_bits-1:0] squash_seq_num,
    input  logic [31:0]               squash_target
);

    localparam int c_SB   = p_seq_num_bits;
    localparam int c_OB   = p_opaq_bits;
    localparam int c_PW   = $clog2(p_buf_depth);
    localparam int c_RW   = $clog2(p_buf_depth + 1);
    localparam int c_FW   = $clog2(p_max_in_flight + 1);
    localparam int c_RING = 1 << p_seq_num_bits;
    localparam logic [c_RW-1:0] c_DEPTH  = c_RW'(p_buf_depth);
    localparam logic [c_FW-1:0] c_MAX_IF = c_FW'(p_max_in_flight);

    logic [31:0]      r_fetch_pc;
    logic             r_epoch;
    logic [c_RW-1:0]  r_num_reserved;
    logic [c_RW-1:0]  r_stale_cnt;

    logic [31:0]      r_pend_pc [p_buf_depth];
    logic [c_PW-1:0]  r_pend_rd;
    logic [c_PW-1:0]  r_pend_wr;
    logic [c_RW-1:0]  r_pend_cnt;

    logic [31:0]      r_q_pc   [p_buf_depth];
    logic [31:0]      r_q_inst [p_buf_depth];
    logic [c_PW-1:0]  r_q_rd;
    logic [c_PW-1:0]  r_q_wr;
    logic [c_RW-1:0]  r_q_cnt;

    logic [c_SB-1:0]  r_seq_head;
    logic [c_SB-1:0]  r_seq_tail;
    logic [c_FW-1:0]  r_in_flight;

    logic             w_req_fire;
    logic             w_resp_keep;
    logic             w_drop;
    logic             w_q_push;
    logic             w_d_fire;
    logic [c_RW-1:0]  w_pend_cnt_nxt;
    logic [c_SB-1:0]  w_seq_head_c;
    logic [c_SB-1:0]  w_seq_tail_sq;
    logic [c_SB-1:0]  w_sq_diff;
    logic [c_FW-1:0]  w_if_sq;
    logic             w_unused_opaq;

    // Requests also wait for stale responses of the previous epoch to drain,
    // so a 1-bit epoch can never alias an old response after another squash.
    assign mem_req_val    = !rst && (r_num_reserved < c_DEPTH) && !squash_val
                            && (r_stale_cnt == '0);
    assign mem_req_addr   = r_fetch_pc;
    assign mem_req_opaque = c_OB'(r_epoch);
    assign mem_resp_rdy   = 1'b1;

    assign D_val     = (r_q_cnt != '0) && (r_in_flight < c_MAX_IF) && !squash_val;
    assign D_inst    = r_q_inst[r_q_rd];
    assign D_pc      = r_q_pc[r_q_rd];
    assign D_seq_num = r_seq_tail;

    assign w_req_fire     = mem_req_val && mem_req_rdy;
    assign w_resp_keep    = mem_resp_val && (mem_resp_opaque[0] == r_epoch)
                            && (r_stale_cnt == '0);
    assign w_drop         = mem_resp_val && !w_resp_keep;
    assign w_q_push       = w_resp_keep && !squash_val;
    assign w_d_fire       = D_val && D_rdy;
    assign w_pend_cnt_nxt = r_pend_cnt + c_RW'(w_req_fire) - c_RW'(mem_resp_val);
    assign w_unused_opaq  = ^mem_resp_opaque;

    // Squash keeps the squashing instruction; a zero ring difference means
    // every sequence number is still allocated.
    assign w_seq_head_c  = r_seq_head + c_SB'(commit_val);
    assign w_seq_tail_sq = squash_seq_num + c_SB'(1);
    assign w_sq_diff     = w_seq_tail_sq - w_seq_head_c;
    assign w_if_sq       = (w_sq_diff == '0) ? c_FW'(c_RING) : c_FW'(w_sq_diff);

    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_pend_pc[r_pend_wr] <= r_fetch_pc;
        end
        if (w_q_push) begin
            r_q_pc[r_q_wr]   <= r_pend_pc[r_pend_rd];
            r_q_inst[r_q_wr] <= mem_resp_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc     <= p_reset_pc;
            r_epoch        <= 1'b0;
            r_num_reserved <= '0;
            r_stale_cnt    <= '0;
            r_pend_rd      <= '0;
            r_pend_wr      <= '0;
            r_pend_cnt     <= '0;
            r_q_rd         <= '0;
            r_q_wr         <= '0;
            r_q_cnt        <= '0;
            r_seq_head     <= '0;
            r_seq_tail     <= '0;
            r_in_flight    <= '0;
        end else begin
            // Responses return in request order, so every one retires a pending PC.
            if (w_req_fire) begin
                r_pend_wr <= r_pend_wr + c_PW'(1);
            end
            if (mem_resp_val) begin
                r_pend_rd <= r_pend_rd + c_PW'(1);
            end
            r_pend_cnt <= w_pend_cnt_nxt;
            r_seq_head <= w_seq_head_c;

            if (squash_val) begin
                r_fetch_pc     <= squash_target;
                r_epoch        <= ~r_epoch;
                r_q_rd         <= '0;
                r_q_wr         <= '0;
                r_q_cnt        <= '0;
                r_num_reserved <= w_pend_cnt_nxt;
                r_stale_cnt    <= w_pend_cnt_nxt;
                r_seq_tail     <= w_seq_tail_sq;
                r_in_flight    <= w_if_sq;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_q_push) begin
                    r_q_wr <= r_q_wr + c_PW'(1);
                end
                if (w_d_fire) begin
                    r_q_rd     <= r_q_rd + c_PW'(1);
                    r_seq_tail <= r_seq_tail + c_SB'(1);
                end
                r_q_cnt        <= r_q_cnt + c_RW'(w_q_push) - c_RW'(w_d_fire);
                r_num_reserved <= r_num_reserved + c_RW'(w_req_fire)
                                  - c_RW'(w_drop) - c_RW'(w_d_fire);
                if (mem_resp_val && (r_stale_cnt != '0)) begin
                    r_stale_cnt <= r_stale_cnt - c_RW'(1);
                end
                r_in_flight <= r_in_flight + c_FW'(w_d_fire) - c_FW'(commit_val);
            end
        end
    end

    a_commit_oldest: assert property (@(posedge clk) disable iff (rst)
        commit_val |-> (commit_seq_num == r_seq_head));

endmodule
`default_nettype wire
